// File: rtl/rob_recovery_ctrl_if.sv
// rtl/rob_recovery_ctrl_if.sv - recovery bus between ROB, rename map, free list and the recovery sequencer
interface rob_recovery_ctrl_if #(
  parameter int TAG_W  = 5,
  parameter int PREG_W = 7,
  parameter int AREG_W = 5
);
  logic              mispredict;
  logic [TAG_W-1:0]  mispredict_tag;
  logic [TAG_W-1:0]  rob_head;
  logic [TAG_W-1:0]  rob_tail;
  logic [TAG_W-1:0]  rd_tag;
  logic              rd_has_dest;
  logic [AREG_W-1:0] rd_areg;
  logic [PREG_W-1:0] rd_pd_new;
  logic [PREG_W-1:0] rd_pd_old;
  logic              map_restore_en;
  logic [AREG_W-1:0] map_restore_areg;
  logic [PREG_W-1:0] map_restore_preg;
  logic              fl_free_en;
  logic [PREG_W-1:0] fl_free_preg;
  logic              stall_rename;
  logic              busy;
  logic              done;
  logic [TAG_W-1:0]  squash_cnt;

  // ROB / pipeline side
  modport master (
    output mispredict, mispredict_tag, rob_head, rob_tail,
    output rd_has_dest, rd_areg, rd_pd_new, rd_pd_old,
    input  rd_tag, map_restore_en, map_restore_areg, map_restore_preg,
    input  fl_free_en, fl_free_preg, stall_rename, busy, done, squash_cnt
  );

  // Recovery sequencer side
  modport slave (
    input  mispredict, mispredict_tag, rob_head, rob_tail,
    input  rd_has_dest, rd_areg, rd_pd_new, rd_pd_old,
    output rd_tag, map_restore_en, map_restore_areg, map_restore_preg,
    output fl_free_en, fl_free_preg, stall_rename, busy, done, squash_cnt
  );
endinterface

// File: rtl/rob_recovery_ctrl.sv
// rtl/rob_recovery_ctrl.sv - youngest-first ROB walk restoring rename map and freeing pregs after a mispredict
module rob_recovery_ctrl #(
  parameter int ROB_DEPTH = 16,
  parameter int TAG_W     = 5,
  parameter int PREG_W    = 7,
  parameter int AREG_W    = 5
) (
  input logic                clk,
  input logic                reset,
  rob_recovery_ctrl_if.slave rec_if
);

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  state_t           state_q;
  logic [TAG_W-1:0] cur_q;
  logic [TAG_W-1:0] end_q;
  logic [TAG_W-1:0] squash_cnt_q;
  logic             done_q;

  logic             older_mp;
  logic [TAG_W-1:0] end_d;
  logic             last_walk;
  logic             walk_dest;

  function automatic logic [TAG_W-1:0] inc_tag(input logic [TAG_W-1:0] t);
    inc_tag = (t == TAG_W'(ROB_DEPTH - 1)) ? '0 : t + TAG_W'(1);
  endfunction

  function automatic logic [TAG_W-1:0] dec_tag(input logic [TAG_W-1:0] t);
    dec_tag = (t == '0) ? TAG_W'(ROB_DEPTH - 1) : t - TAG_W'(1);
  endfunction

  // Age of a tag relative to the ROB head; smaller is older.
  function automatic logic [TAG_W-1:0] dist_tag(input logic [TAG_W-1:0] t,
                                                input logic [TAG_W-1:0] head);
    dist_tag = (t >= head) ? t - head : t + TAG_W'(ROB_DEPTH) - head;
  endfunction

  // Older mispredict during the walk moves the stop point, effective this same cycle.
  always_comb begin
    older_mp  = rec_if.mispredict && (state_q == WALK) &&
                (dist_tag(rec_if.mispredict_tag, rec_if.rob_head) < dist_tag(end_q, rec_if.rob_head));
    end_d     = older_mp ? rec_if.mispredict_tag : end_q;
    last_walk = (cur_q == inc_tag(end_d));
  end

  assign walk_dest               = reset && (state_q == WALK) && rec_if.rd_has_dest;
  assign rec_if.rd_tag           = cur_q;
  assign rec_if.map_restore_en   = walk_dest;
  assign rec_if.map_restore_areg = rec_if.rd_areg;
  assign rec_if.map_restore_preg = rec_if.rd_pd_old;
  assign rec_if.fl_free_en       = walk_dest;
  assign rec_if.fl_free_preg     = rec_if.rd_pd_new;
  assign rec_if.stall_rename     = rec_if.mispredict || (state_q != IDLE);
  assign rec_if.busy             = (state_q != IDLE);
  assign rec_if.done             = done_q;
  assign rec_if.squash_cnt       = squash_cnt_q;

  // Recovery FSM: start on mispredict, walk one entry per cycle, pulse done after DONE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      cur_q        <= '0;
      end_q        <= '0;
      squash_cnt_q <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rec_if.mispredict) begin
            squash_cnt_q <= '0;
            if (rec_if.rob_tail == inc_tag(rec_if.mispredict_tag)) begin
              state_q <= DONE;
            end else begin
              cur_q   <= dec_tag(rec_if.rob_tail);
              end_q   <= rec_if.mispredict_tag;
              state_q <= WALK;
            end
          end
        end
        WALK: begin
          squash_cnt_q <= squash_cnt_q + TAG_W'(1);
          end_q        <= end_d;
          if (last_walk) begin
            state_q <= DONE;
          end else begin
            cur_q <= dec_tag(cur_q);
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rob_recovery_ctrl.sv
// tb/tb_rob_recovery_ctrl.sv - randomized self-checking bench for rob_recovery_ctrl against a walk-list model
module tb_rob_recovery_ctrl;
  localparam int DEPTH  = 16;
  localparam int TAG_W  = 5;
  localparam int PREG_W = 7;
  localparam int AREG_W = 5;

  logic clk = 1'b0;
  logic reset;
  int   tests_run = 0;
  int   tests_failed = 0;

  logic              has_m  [DEPTH];
  logic [AREG_W-1:0] areg_m [DEPTH];
  logic [PREG_W-1:0] pnew_m [DEPTH];
  logic [PREG_W-1:0] pold_m [DEPTH];

  rob_recovery_ctrl_if #(.TAG_W(TAG_W), .PREG_W(PREG_W), .AREG_W(AREG_W)) rec_if ();

  rob_recovery_ctrl #(.ROB_DEPTH(DEPTH), .TAG_W(TAG_W), .PREG_W(PREG_W), .AREG_W(AREG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .rec_if(rec_if)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // ROB array answers reads combinationally at rd_tag.
  always_comb begin
    rec_if.rd_has_dest = has_m[rec_if.rd_tag[3:0]];
    rec_if.rd_areg     = areg_m[rec_if.rd_tag[3:0]];
    rec_if.rd_pd_new   = pnew_m[rec_if.rd_tag[3:0]];
    rec_if.rd_pd_old   = pold_m[rec_if.rd_tag[3:0]];
  end

  function automatic int m16(input int x);
    return ((x % DEPTH) + DEPTH) % DEPTH;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // dest_mode: 0 random, 1 all entries write a register, 2 all except entry 2.
  task automatic run_case(input int head, input int tail, input int tag,
                          input int inj_k, input int inj_tag, input int rst_k,
                          input int dest_mode, input bit dn_mp);
    int n;
    int endt;
    int et;
    for (int i = 0; i < DEPTH; i++) begin
      has_m[i]  = (dest_mode == 0) ? 1'($urandom_range(0, 1)) : !(dest_mode == 2 && i == 2);
      areg_m[i] = AREG_W'($urandom);
      pnew_m[i] = PREG_W'($urandom);
      pold_m[i] = PREG_W'($urandom);
    end
    endt = tag;
    n    = m16(tail - tag - 1);

    @(negedge clk);
    rec_if.mispredict     = 1'b1;
    rec_if.mispredict_tag = TAG_W'(tag);
    rec_if.rob_head       = TAG_W'(head);
    rec_if.rob_tail       = TAG_W'(tail);
    #1;
    check_eq("stall_in_mp_cycle", rec_if.stall_rename, 1);
    check_eq("busy_in_mp_cycle", rec_if.busy, 0);

    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rec_if.mispredict     = (k == inj_k);
      rec_if.mispredict_tag = TAG_W'(inj_tag);
      if (k == rst_k) begin
        reset = 1'b0;
        rec_if.mispredict = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("rst_busy", rec_if.busy, 0);
        check_eq("rst_stall", rec_if.stall_rename, 0);
        check_eq("rst_map_en", rec_if.map_restore_en, 0);
        check_eq("rst_free_en", rec_if.fl_free_en, 0);
        check_eq("rst_squash_cnt", rec_if.squash_cnt, 0);
        return;
      end
      #1;
      if (k == inj_k && m16(inj_tag - head) < m16(endt - head)) begin
        endt = inj_tag;
        n    = m16(tail - inj_tag - 1);
      end
      et = m16(tail - 1 - k);
      check_eq("walk_rd_tag", rec_if.rd_tag, et);
      check_eq("walk_busy", rec_if.busy, 1);
      check_eq("walk_stall", rec_if.stall_rename, 1);
      check_eq("walk_done", rec_if.done, 0);
      check_eq("walk_map_en", rec_if.map_restore_en, has_m[et]);
      check_eq("walk_free_en", rec_if.fl_free_en, has_m[et]);
      if (has_m[et]) begin
        check_eq("walk_map_areg", rec_if.map_restore_areg, areg_m[et]);
        check_eq("walk_map_preg", rec_if.map_restore_preg, pold_m[et]);
        check_eq("walk_free_preg", rec_if.fl_free_preg, pnew_m[et]);
      end
    end

    @(negedge clk);
    rec_if.mispredict     = dn_mp;
    rec_if.mispredict_tag = TAG_W'(m16(tail - 1));
    #1;
    check_eq("done_state_busy", rec_if.busy, 1);
    check_eq("done_state_stall", rec_if.stall_rename, 1);
    check_eq("done_state_map_en", rec_if.map_restore_en, 0);
    check_eq("done_state_done", rec_if.done, 0);

    @(negedge clk);
    rec_if.mispredict = 1'b0;
    #1;
    check_eq("done_pulse", rec_if.done, 1);
    check_eq("done_busy", rec_if.busy, 0);
    check_eq("done_stall", rec_if.stall_rename, 0);
    check_eq("squash_cnt", rec_if.squash_cnt, n);

    @(negedge clk);
    #1;
    check_eq("done_one_cycle", rec_if.done, 0);
    check_eq("idle_after_done", rec_if.busy, 0);
    check_eq("squash_cnt_held", rec_if.squash_cnt, n);
  endtask

  initial begin
    int head;
    int occ;
    int tag;
    reset                 = 1'b0;
    rec_if.mispredict     = 1'b0;
    rec_if.mispredict_tag = '0;
    rec_if.rob_head       = '0;
    rec_if.rob_tail       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      has_m[i]  = 1'b0;
      areg_m[i] = '0;
      pnew_m[i] = '0;
      pold_m[i] = '0;
    end
    repeat (2) @(negedge clk);
    #1;
    check_eq("reset_busy", rec_if.busy, 0);
    check_eq("reset_done", rec_if.done, 0);
    check_eq("reset_rd_tag", rec_if.rd_tag, 0);
    check_eq("reset_squash_cnt", rec_if.squash_cnt, 0);
    check_eq("reset_map_en", rec_if.map_restore_en, 0);
    check_eq("reset_free_en", rec_if.fl_free_en, 0);
    check_eq("reset_stall", rec_if.stall_rename, 0);
    reset = 1'b1;

    run_case(0, 4, 1, -1, 0, -1, 1, 1'b0);
    run_case(0, 2, 1, -1, 0, -1, 0, 1'b0);
    run_case(14, 2, 15, -1, 0, -1, 0, 1'b0);
    run_case(5, 5, 5, -1, 0, -1, 0, 1'b1);
    run_case(0, 4, 0, -1, 0, -1, 2, 1'b0);
    run_case(0, 8, 5, 1, 2, -1, 0, 1'b0);
    run_case(0, 8, 5, 1, 6, -1, 0, 1'b0);
    run_case(0, 10, 0, -1, 0, 3, 0, 1'b0);

    for (int r = 0; r < 40; r++) begin
      head = $urandom_range(0, DEPTH - 1);
      occ  = $urandom_range(1, DEPTH);
      tag  = head + $urandom_range(0, occ - 1);
      run_case(head, m16(head + occ), m16(tag),
               ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : -1,
               m16(head + $urandom_range(0, occ - 1)),
               ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : -1,
               0, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
